// File: rtl/vga_sync_decode.sv
// Receive-side sync decoder: rebuilds column/row counters from an incoming
// HSync/VSync pair and qualifies the timing into a lock indication.
module vga_sync_decode #(
   parameter int TOTAL_COLS  = 800,
   parameter int TOTAL_ROWS  = 525,
   parameter int ACTIVE_COLS = 640,
   parameter int ACTIVE_ROWS = 480,
   parameter int LOCK_FRAMES = 2
) (
   input  logic       i_Clk,
   input  logic       i_Rst,
   input  logic       i_HSync,
   input  logic       i_VSync,
   output logic       o_HSync,
   output logic       o_VSync,
   output logic [9:0] o_Col_Count,
   output logic [9:0] o_Row_Count,
   output logic       o_Frame_Start,
   output logic       o_Locked,
   output logic       o_Sync_Err
);

   localparam logic [9:0]  COL_LAST  = 10'(TOTAL_COLS - 1);
   localparam logic [9:0]  ROW_LAST  = 10'(TOTAL_ROWS - 1);
   localparam logic [9:0]  HACT_LAST = 10'(ACTIVE_COLS - 1);
   localparam logic [9:0]  VACT_LAST = 10'(ACTIVE_ROWS - 1);
   localparam logic [19:0] TO_LAST   = 20'(2 * TOTAL_COLS * TOTAL_ROWS - 1);
   localparam logic [7:0]  GOOD_LAST = 8'(LOCK_FRAMES - 1);

   typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_e;

   state_e      state_q, state_d;
   logic        hSync_q, vSync_q;
   logic [9:0]  colCount_q, colCount_d;
   logic [9:0]  rowCount_q, rowCount_d, rowNext;
   logic        frameStart_q;
   logic        syncErr_q, syncErr_d;
   logic        locked_q, locked_d;
   logic [7:0]  good_q, good_d;
   logic        dirty_q, dirty_d;
   logic [19:0] timeout_q, timeout_d;
   logic        hRise, hFall, vRise, vFall;
   logic        mismatch, timeoutHit;

   // Edges compare the live input against last cycle's registered copy.
   always_comb begin
      hRise    = i_HSync & ~hSync_q;
      hFall    = ~i_HSync & hSync_q;
      vRise    = i_VSync & ~vSync_q;
      vFall    = ~i_VSync & vSync_q;
      mismatch = 1'b0;
      if (vRise) begin
         if (colCount_q != COL_LAST || rowCount_q != ROW_LAST) mismatch = 1'b1;
      end else if (hRise && colCount_q != COL_LAST) begin
         mismatch = 1'b1;
      end
      if (hFall && colCount_q != HACT_LAST) mismatch = 1'b1;
      if (vFall && (colCount_q != COL_LAST || rowCount_q != VACT_LAST)) mismatch = 1'b1;
   end

   always_comb begin
      rowNext    = (rowCount_q == ROW_LAST) ? 10'd0 : rowCount_q + 10'd1;
      colCount_d = colCount_q + 10'd1;
      rowCount_d = rowCount_q;
      if (vRise) begin
         colCount_d = 10'd0;
         rowCount_d = 10'd0;
      end else if (hRise || colCount_q == COL_LAST) begin
         colCount_d = 10'd0;
         rowCount_d = rowNext;
      end
   end

   // A frame is clean only if nothing went wrong since the previous VSync rise.
   always_comb begin
      state_d    = state_q;
      good_d     = good_q;
      dirty_d    = vRise ? 1'b0 : (dirty_q | mismatch);
      timeoutHit = ~vRise && (timeout_q == TO_LAST);
      timeout_d  = (vRise || timeoutHit) ? 20'd0 : timeout_q + 20'd1;
      case (state_q)
         UNLOCKED: begin
            if (vRise) begin
               state_d = ACQUIRE;
               good_d  = 8'd0;
            end
         end
         ACQUIRE: begin
            if (mismatch) begin
               good_d = 8'd0;
            end else if (vRise && !dirty_q) begin
               good_d = good_q + 8'd1;
               if (good_q == GOOD_LAST) state_d = LOCKED;
            end
         end
         LOCKED: begin
            if (mismatch) begin
               state_d = ACQUIRE;
               good_d  = 8'd0;
            end
         end
         default: state_d = UNLOCKED;
      endcase
      if (timeoutHit) begin
         state_d = UNLOCKED;
         good_d  = 8'd0;
      end
      syncErr_d = timeoutHit | (mismatch & (state_q != UNLOCKED));
      locked_d  = (state_d == LOCKED);
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state_q      <= UNLOCKED;
         hSync_q      <= 1'b0;
         vSync_q      <= 1'b0;
         colCount_q   <= 10'd0;
         rowCount_q   <= 10'd0;
         frameStart_q <= 1'b0;
         syncErr_q    <= 1'b0;
         locked_q     <= 1'b0;
         good_q       <= 8'd0;
         dirty_q      <= 1'b0;
         timeout_q    <= 20'd0;
      end else begin
         state_q      <= state_d;
         hSync_q      <= i_HSync;
         vSync_q      <= i_VSync;
         colCount_q   <= colCount_d;
         rowCount_q   <= rowCount_d;
         frameStart_q <= vRise;
         syncErr_q    <= syncErr_d;
         locked_q     <= locked_d;
         good_q       <= good_d;
         dirty_q      <= dirty_d;
         timeout_q    <= timeout_d;
      end
   end

   assign o_HSync       = hSync_q;
   assign o_VSync       = vSync_q;
   assign o_Col_Count   = colCount_q;
   assign o_Row_Count   = rowCount_q;
   assign o_Frame_Start = frameStart_q;
   assign o_Locked      = locked_q;
   assign o_Sync_Err    = syncErr_q;

endmodule
